header_frame_tracker: RTL
=========================

// Module: header_frame_tracker
// PURPOSE
//  Parametrised successor to the fixed 6-word header detector. Finds a run of HDR_LEN
//  consecutive header-tagged words on the 16-bit front-end stream and locks to the frame.
//  Delimits fixed-length payloads with sop/eop and checks every following header in-line.
//  Flywheels over up to MISS_LIMIT-1 bad headers before dropping lock.
//  Sits between the deserialiser word output and the event packer.
// PARAMETERS
//  DATA_W      16      word width
//  TAG_W       2       header tag width, taken from din[DATA_W-1 -: TAG_W]
//  HDR_TAG     2'b11   tag value marking a header word
//  HDR_LEN     6       header words per frame, >=1
//  PAYLOAD_LEN 64      payload words per frame, >=2
//  MISS_LIMIT  3       consecutive bad headers that drop lock, >=1
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous reset, active-high
//  din          in   DATA_W  input word
//  din_valid    in   1       din qualifier; low = stall, no state change
//  hdr_found    out  1       1-cycle pulse: a good header completed (search or check)
//  lock         out  1       frame lock held
//  pkt_data     out  DATA_W  payload word
//  pkt_valid    out  1       pkt_data qualifier
//  pkt_sop      out  1       first payload word of a frame, with pkt_valid
//  pkt_eop      out  1       last payload word of a frame, with pkt_valid
//  pkt_cnt      out  16      good-header count, wraps at 2^16
//  hdr_err_cnt  out  16      bad-header count, saturates at 16'hFFFF
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (rst).
//  - Reset: all outputs 0, state SEARCH, run/word/miss counters 0.
//  - rst wins over all other inputs and aborts any frame in progress. No eop is emitted.
//  - An accepted word is one with din_valid=1. Stall cycles hold all state and counters.
//  - match = (din tag == HDR_TAG).
//  - SEARCH: run counter increments on an accepted match and clears on an accepted non-match.
//    - The accepted word that brings run to HDR_LEN moves the FSM to PAYLOAD.
//    - Same transition sets lock=1 and miss=0, clears run, and increments pkt_cnt.
//    - hdr_found pulses in the next cycle.
//    - Run never exceeds HDR_LEN. Extra header words before a non-match are not used.
//  - PAYLOAD: accepts exactly PAYLOAD_LEN words regardless of tag. Tagged words are valid data.
//    - Each word is registered to pkt_data with pkt_valid=1, one cycle after acceptance.
//    - pkt_sop is set on word 0 and pkt_eop on word PAYLOAD_LEN-1.
//    - After the last word the FSM goes to CHECK.
//  - CHECK: accepts exactly HDR_LEN words and ANDs match across them. No early exit.
//    - All matched: pkt_cnt++, miss=0, hdr_found pulse, back to PAYLOAD.
//    - Any mismatch: hdr_err_cnt++ (saturating) and miss++.
//      - miss==MISS_LIMIT after the increment: lock=0, miss=0, go to SEARCH.
//      - Otherwise (flywheel): lock stays 1 and the FSM returns to PAYLOAD.
//  - Output latency is 1 cycle everywhere. pkt_valid/sop/eop/hdr_found are 0 when not asserted.
//  - No payload is output while in SEARCH or CHECK.
//  - pkt_cnt wraps modulo 2^16. Word/run counters are sized by $clog2 of the max count.
// TESTING
//  T1 6x16'hC000 then 64 payload words 16'h0000..003F
//     -> hdr_found 1 cycle after 6th header.
//     -> pkt_sop on data 0, pkt_eop on data 0x3F, lock=1, pkt_cnt=1.
//  T2 5 headers, 1x16'h1234, 6 headers
//     -> no lock after the first 5.
//     -> lock after the second run, payload starts on the following word.
//  T3 locked; next header word 3 = 16'h4000 (x3 frames)
//     -> hdr_err_cnt 1,2,3.
//     -> first two frames still output; lock drops after the 3rd CHECK; FSM in SEARCH.
//  T4 locked; din_valid low for 10 cycles mid-payload
//     -> no pkt_valid during the stall; sop/eop positions and pkt_cnt unchanged.
//  T5 rst=1 for 1 cycle at payload word 30 -> all outputs 0 next cycle, no eop.
//     -> A fresh 6-header run re-locks.
//  T6 payload containing 16'hFFFF words -> passed as data, no spurious hdr_found.

Source files
------------

// File: rtl/header_frame_tracker.sv
`default_nettype none
// ============================================================================
// Module      : header_frame_tracker
// Description : Locks to a frame made of HDR_LEN header-tagged words followed
//               by PAYLOAD_LEN payload words. Payload is forwarded with
//               sop/eop delimiters. Every following header is checked in-line,
//               and lock is held across up to MISS_LIMIT-1 bad headers in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module header_frame_tracker #(
  parameter int                 DATA_W      = 16,
  parameter int                 TAG_W       = 2,
  parameter logic [TAG_W-1:0]   HDR_TAG     = 2'b11,
  parameter int                 HDR_LEN     = 6,
  parameter int                 PAYLOAD_LEN = 64,
  parameter int                 MISS_LIMIT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              hdr_found,
  output logic              lock,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_valid,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       hdr_err_cnt
);

  // Counter widths: run counts up to HDR_LEN; one word counter serves both
  // the payload and the header-check phases, so it covers the larger of the two.
  localparam int C_RUN_W  = $clog2(HDR_LEN + 1);
  localparam int C_WMAX   = (PAYLOAD_LEN > HDR_LEN) ? PAYLOAD_LEN : HDR_LEN;
  localparam int C_WCNT_W = $clog2(C_WMAX);
  localparam int C_MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [C_RUN_W-1:0]  C_RUN_FULL = C_RUN_W'(HDR_LEN);
  localparam logic [C_RUN_W-1:0]  C_RUN_ONE  = C_RUN_W'(1);
  localparam logic [C_WCNT_W-1:0] C_PAY_LAST = C_WCNT_W'(PAYLOAD_LEN - 1);
  localparam logic [C_WCNT_W-1:0] C_CHK_LAST = C_WCNT_W'(HDR_LEN - 1);
  localparam logic [C_WCNT_W-1:0] C_WORD_ONE = C_WCNT_W'(1);
  localparam logic [C_MISS_W-1:0] C_MISS_MAX = C_MISS_W'(MISS_LIMIT);
  localparam logic [C_MISS_W-1:0] C_MISS_ONE = C_MISS_W'(1);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t              state_q,       state_d;
  logic [C_RUN_W-1:0]  run_q,         run_d;
  logic [C_WCNT_W-1:0] word_q,        word_d;
  logic [C_MISS_W-1:0] miss_q,        miss_d;
  logic                ok_q,          ok_d;
  logic                lock_q,        lock_d;
  logic                hdr_found_q,   hdr_found_d;
  logic [DATA_W-1:0]   pkt_data_q,    pkt_data_d;
  logic                pkt_valid_q,   pkt_valid_d;
  logic                pkt_sop_q,     pkt_sop_d;
  logic                pkt_eop_q,     pkt_eop_d;
  logic [15:0]         pkt_cnt_q,     pkt_cnt_d;
  logic [15:0]         hdr_err_cnt_q, hdr_err_cnt_d;

  logic w_match;
  logic w_hdr_ok;

  assign w_match  = (din[DATA_W-1 -: TAG_W] == HDR_TAG);
  // Running AND over the check window, including the current word.
  assign w_hdr_ok = ok_q & w_match;

  // Next-state, counter and output computation; nothing changes on stall cycles.
  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    word_d        = word_q;
    miss_d        = miss_q;
    ok_d          = ok_q;
    lock_d        = lock_q;
    pkt_cnt_d     = pkt_cnt_q;
    hdr_err_cnt_d = hdr_err_cnt_q;
    pkt_data_d    = pkt_data_q;
    hdr_found_d   = 1'b0;
    pkt_valid_d   = 1'b0;
    pkt_sop_d     = 1'b0;
    pkt_eop_d     = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        S_SEARCH: begin
          if (w_match) begin
            if ((run_q + C_RUN_ONE) == C_RUN_FULL) begin
              state_d     = S_PAYLOAD;
              run_d       = '0;
              word_d      = '0;
              lock_d      = 1'b1;
              miss_d      = '0;
              pkt_cnt_d   = pkt_cnt_q + 16'd1;
              hdr_found_d = 1'b1;
            end else begin
              run_d = run_q + C_RUN_ONE;
            end
          end else begin
            run_d = '0;
          end
        end

        S_PAYLOAD: begin
          // Tag is ignored here: every word is payload.
          pkt_data_d  = din;
          pkt_valid_d = 1'b1;
          pkt_sop_d   = (word_q == '0);
          pkt_eop_d   = (word_q == C_PAY_LAST);
          if (word_q == C_PAY_LAST) begin
            word_d  = '0;
            ok_d    = 1'b1;
            state_d = S_CHECK;
          end else begin
            word_d = word_q + C_WORD_ONE;
          end
        end

        S_CHECK: begin
          // The full header window is always consumed so frame alignment
          // is preserved even when an early word is already bad.
          if (word_q == C_CHK_LAST) begin
            word_d = '0;
            if (w_hdr_ok) begin
              pkt_cnt_d   = pkt_cnt_q + 16'd1;
              miss_d      = '0;
              hdr_found_d = 1'b1;
              state_d     = S_PAYLOAD;
            end else begin
              if (hdr_err_cnt_q != 16'hFFFF) begin
                hdr_err_cnt_d = hdr_err_cnt_q + 16'd1;
              end
              if ((miss_q + C_MISS_ONE) == C_MISS_MAX) begin
                lock_d  = 1'b0;
                miss_d  = '0;
                run_d   = '0;
                state_d = S_SEARCH;
              end else begin
                miss_d  = miss_q + C_MISS_ONE;
                state_d = S_PAYLOAD;
              end
            end
          end else begin
            word_d = word_q + C_WORD_ONE;
            ok_d   = w_hdr_ok;
          end
        end

        default: begin
          state_d = S_SEARCH;
          run_d   = '0;
          word_d  = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_SEARCH;
      run_q         <= '0;
      word_q        <= '0;
      miss_q        <= '0;
      ok_q          <= 1'b0;
      lock_q        <= 1'b0;
      hdr_found_q   <= 1'b0;
      pkt_data_q    <= '0;
      pkt_valid_q   <= 1'b0;
      pkt_sop_q     <= 1'b0;
      pkt_eop_q     <= 1'b0;
      pkt_cnt_q     <= '0;
      hdr_err_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      word_q        <= word_d;
      miss_q        <= miss_d;
      ok_q          <= ok_d;
      lock_q        <= lock_d;
      hdr_found_q   <= hdr_found_d;
      pkt_data_q    <= pkt_data_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_sop_q     <= pkt_sop_d;
      pkt_eop_q     <= pkt_eop_d;
      pkt_cnt_q     <= pkt_cnt_d;
      hdr_err_cnt_q <= hdr_err_cnt_d;
    end
  end

  assign hdr_found   = hdr_found_q;
  assign lock        = lock_q;
  assign pkt_data    = pkt_data_q;
  assign pkt_valid   = pkt_valid_q;
  assign pkt_sop     = pkt_sop_q;
  assign pkt_eop     = pkt_eop_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign hdr_err_cnt = hdr_err_cnt_q;

endmodule
`default_nettype wire
